// File: rtl/bench_bist.sv
// BIST harness: an LFSR fills a wide pattern register feeding a benchmark and a MISR compacts its
// response. Optional golden compare with pass flag when BENCH_BIST_GOLDEN_EN is defined.
module bench_bist #(
    parameter int unsigned PI_W  = 192,
    parameter int unsigned PO_W  = 6,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] num_pat,
    input  logic [31:0]      seed,
`ifdef BENCH_BIST_GOLDEN_EN
    input  logic [31:0]      golden,
    output logic             pass,
`endif
    output logic [PI_W-1:0]  pi_o,
    input  logic [PO_W-1:0]  po_i,
    output logic             busy,
    output logic             done,
    output logic [31:0]      signature
);

    localparam logic [31:0] Poly  = 32'h00400007;
    localparam int unsigned FillW = (PI_W > 1) ? $clog2(PI_W) : 1;

    typedef enum logic [2:0] {StIdle, StLoad, StFill, StRun, StDone} state_e;

    state_e             state_q, state_d;
    logic [PI_W-1:0]    pi_q, pi_d;
    logic [31:0]        lfsr_q, lfsr_d;
    logic [31:0]        misr_q, misr_d;
    logic [31:0]        seed_q, seed_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [FillW-1:0]   fill_q, fill_d;

    logic               accept;
    logic               abort_run;
    logic [31:0]        po_ext;

    function automatic logic [31:0] galois(input logic [31:0] r);
        return {r[30:0], 1'b0} ^ (r[31] ? Poly : 32'h0);
    endfunction

    assign po_ext    = 32'(po_i);
    assign accept    = (state_q == StIdle) && start && !abort;
    assign abort_run = abort && busy;

    always_comb begin
        busy = (state_q == StLoad) || (state_q == StFill) || (state_q == StRun);
        done = (state_q == StDone);
    end

    always_comb begin
        state_d = state_q;
        pi_d    = pi_q;
        lfsr_d  = lfsr_q;
        misr_d  = misr_q;
        seed_d  = seed_q;
        cnt_d   = cnt_q;
        fill_d  = fill_q;

        if (abort_run) begin
            // Abort wins over every other transition; pattern and LFSR are simply frozen.
            state_d = StIdle;
            misr_d  = 32'h0;
            cnt_d   = '0;
            fill_d  = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        state_d = StLoad;
                        cnt_d   = num_pat;
                        seed_d  = seed;
                        misr_d  = 32'h0;
                    end
                end
                StLoad: begin
                    lfsr_d  = (seed_q == 32'h0) ? 32'h1 : seed_q;
                    fill_d  = '0;
                    state_d = StFill;
                end
                StFill: begin
                    pi_d   = {pi_q[PI_W-2:0], lfsr_q[31]};
                    lfsr_d = galois(lfsr_q);
                    fill_d = fill_q + 1'b1;
                    if (fill_q == FillW'(PI_W - 1)) begin
                        fill_d  = '0;
                        state_d = (cnt_q == '0) ? StDone : StRun;
                    end
                end
                StRun: begin
                    pi_d   = {pi_q[PI_W-2:0], lfsr_q[31]};
                    lfsr_d = galois(lfsr_q);
                    misr_d = galois(misr_q) ^ po_ext;
                    cnt_d  = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = StDone;
                    end
                end
                StDone: begin
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            pi_q    <= '0;
            lfsr_q  <= 32'h0;
            misr_q  <= 32'h0;
            seed_q  <= 32'h0;
            cnt_q   <= '0;
            fill_q  <= '0;
        end else begin
            state_q <= state_d;
            pi_q    <= pi_d;
            lfsr_q  <= lfsr_d;
            misr_q  <= misr_d;
            seed_q  <= seed_d;
            cnt_q   <= cnt_d;
            fill_q  <= fill_d;
        end
    end

    assign pi_o      = pi_q;
    assign signature = misr_q;

`ifdef BENCH_BIST_GOLDEN_EN
    logic [31:0] golden_q, golden_d;
    logic        pass_q, pass_d;

    always_comb begin
        golden_d = golden_q;
        pass_d   = pass_q;
        if (accept) begin
            golden_d = golden;
            pass_d   = 1'b0;
        end else if (abort_run) begin
            pass_d = 1'b0;
        end else if (state_q == StDone) begin
            pass_d = (misr_q == golden_q);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            golden_q <= 32'h0;
            pass_q   <= 1'b0;
        end else begin
            golden_q <= golden_d;
            pass_q   <= pass_d;
        end
    end

    assign pass = pass_q;
`endif

endmodule

// File: tb/tb_bench_bist.sv
// Self-checking bench for bench_bist: timeline-based reference model plus directed literal checks.
module tb_bench_bist;

    localparam int PI_W  = 192;
    localparam int PO_W  = 6;
    localparam int CNT_W = 16;
    localparam logic [31:0] POLY = 32'h00400007;

    logic             clock   = 1'b0;
    logic             reset_n = 1'b1;
    logic             start   = 1'b0;
    logic             abort   = 1'b0;
    logic [CNT_W-1:0] num_pat = '0;
    logic [31:0]      seed    = 32'h0;
    logic [31:0]      golden  = 32'h0;
    logic [PI_W-1:0]  pi_o;
    logic [PO_W-1:0]  po_i;
    logic             busy;
    logic             done;
    logic [31:0]      signature;
`ifdef BENCH_BIST_GOLDEN_EN
    logic             pass;
`endif

    bit               po_mode  = 1'b0;
    logic [PO_W-1:0]  po_const = '0;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clock = ~clock;

    function automatic logic [31:0] gal(input logic [31:0] r);
        return {r[30:0], 1'b0} ^ (r[31] ? POLY : 32'h0);
    endfunction

    // Stand-in combinational benchmark.
    function automatic logic [PO_W-1:0] po_func(input logic [PI_W-1:0] p);
        return p[PO_W-1:0] ^ p[PI_W-1 -: PO_W] ^ p[100 -: PO_W];
    endfunction

    assign po_i = po_mode ? po_func(pi_o) : po_const;

    bench_bist #(.PI_W(PI_W), .PO_W(PO_W), .CNT_W(CNT_W)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .abort     (abort),
        .num_pat   (num_pat),
        .seed      (seed),
`ifdef BENCH_BIST_GOLDEN_EN
        .golden    (golden),
        .pass      (pass),
`endif
        .pi_o      (pi_o),
        .po_i      (po_i),
        .busy      (busy),
        .done      (done),
        .signature (signature)
    );

    task automatic chk(input string nm, input logic [PI_W-1:0] act, input logic [PI_W-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    endtask

    // Model: m_t counts cycles since the accepted start (0 = load, 1..PI_W fill, then runs, done).
    bit              m_active = 1'b0;
    int              m_t      = 0;
    int              m_n      = 0;
    logic [31:0]     m_seed   = 32'h0;
    logic [31:0]     m_lfsr   = 32'h0;
    logic [31:0]     m_sig    = 32'h0;
    logic [31:0]     m_gold   = 32'h0;
    logic [PI_W-1:0] m_pi     = '0;
    bit              m_pass   = 1'b0;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_active <= 1'b0;
            m_t      <= 0;
            m_n      <= 0;
            m_lfsr   <= 32'h0;
            m_sig    <= 32'h0;
            m_pi     <= '0;
            m_pass   <= 1'b0;
        end else if (!m_active) begin
            if (start && !abort) begin
                m_active <= 1'b1;
                m_t      <= 0;
                m_n      <= int'(num_pat);
                m_seed   <= seed;
                m_sig    <= 32'h0;
                m_gold   <= golden;
                m_pass   <= 1'b0;
            end
        end else if (abort && m_t <= PI_W + m_n) begin
            m_active <= 1'b0;
            m_sig    <= 32'h0;
            m_pass   <= 1'b0;
        end else begin
            m_t <= m_t + 1;
            if (m_t == 0) begin
                m_lfsr <= (m_seed == 32'h0) ? 32'h1 : m_seed;
            end else if (m_t <= PI_W + m_n) begin
                if (m_t > PI_W)
                    m_sig <= gal(m_sig) ^ 32'(po_mode ? po_func(m_pi) : po_const);
                m_pi   <= {m_pi[PI_W-2:0], m_lfsr[31]};
                m_lfsr <= gal(m_lfsr);
            end else begin
                m_active <= 1'b0;
                m_pass   <= (m_sig == m_gold);
            end
        end
    end

    always @(negedge clock) begin
        if (reset_n) begin
            chk("busy", PI_W'(busy), PI_W'(m_active && m_t <= PI_W + m_n));
            chk("done", PI_W'(done), PI_W'(m_active && m_t == PI_W + m_n + 1));
            chk("pi_o", pi_o, m_pi);
            chk("signature", PI_W'(signature), PI_W'(m_sig));
`ifdef BENCH_BIST_GOLDEN_EN
            chk("pass", PI_W'(pass), PI_W'(m_pass));
`endif
        end
    end

    task automatic run(input logic [31:0] s, input int n, input bit mode,
                       input logic [PO_W-1:0] pc, input logic [31:0] g, input int abort_at,
                       input bit start_glitch, output int busy_cyc, output int done_cnt);
        @(posedge clock); #1;
        seed = s; num_pat = CNT_W'(n); po_mode = mode; po_const = pc; golden = g; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        busy_cyc = 0;
        done_cnt = 0;
        for (int k = 0; k < PI_W + n + 4; k++) begin
            abort = (k == abort_at);
            start = start_glitch && k >= 5 && k < PI_W + 5;
            @(negedge clock);
            if (busy) busy_cyc++;
            if (done) done_cnt++;
            @(posedge clock); #1;
        end
        abort = 1'b0;
        start = 1'b0;
    endtask

    initial begin
        int bc, dc, n, ab;
        logic [31:0] exp_sig [3];
        exp_sig = '{32'h1, 32'h3, 32'h7};

        #1 reset_n = 1'b0;
        #22 reset_n = 1'b1;
        @(negedge clock);
        chk("reset busy", PI_W'(busy), '0);
        chk("reset done", PI_W'(done), '0);
        chk("reset pi_o", pi_o, '0);
        chk("reset signature", PI_W'(signature), '0);

        // Zero-length run with zero seed.
        run(32'h0, 0, 1'b0, 6'h01, 32'h0, -1, 1'b0, bc, dc);
        chk("zero busy cycles", PI_W'(bc), PI_W'(193));
        chk("zero done count", PI_W'(dc), PI_W'(1));
        chk("zero signature", PI_W'(signature), '0);
        chk("zero pi_o[0]", PI_W'(pi_o[0]), '0);

        // Constant response.
        for (int i = 0; i < 3; i++) begin
            run($urandom, i + 1, 1'b0, 6'h01, 32'h0, -1, 1'b0, bc, dc);
            chk("const signature", PI_W'(signature), PI_W'(exp_sig[i]));
            chk("const done count", PI_W'(dc), PI_W'(1));
        end

        // Quiet response.
        run($urandom, 100, 1'b0, 6'h00, 32'h0, -1, 1'b0, bc, dc);
        chk("quiet signature", PI_W'(signature), '0);
        chk("quiet done count", PI_W'(dc), PI_W'(1));

        // Start held during the run is ignored.
        run($urandom, 10, 1'b1, 6'h00, 32'h0, -1, 1'b1, bc, dc);
        chk("glitch done count", PI_W'(dc), PI_W'(1));
        chk("glitch busy cycles", PI_W'(bc), PI_W'(PI_W + 11));

        // Abort in the fifth run cycle.
        run($urandom, 50, 1'b1, 6'h00, 32'h0, PI_W + 5, 1'b0, bc, dc);
        chk("abort done count", PI_W'(dc), '0);
        chk("abort busy cycles", PI_W'(bc), PI_W'(PI_W + 6));
        chk("abort signature", PI_W'(signature), '0);

        // Start together with abort in idle is no start; abort alone in idle does nothing.
        @(posedge clock); #1 start = 1'b1; abort = 1'b1;
        @(posedge clock); #1 start = 1'b0;
        @(negedge clock);
        chk("start+abort idle busy", PI_W'(busy), '0);
        abort = 1'b0;

`ifdef BENCH_BIST_GOLDEN_EN
        run($urandom, 2, 1'b0, 6'h01, 32'h3, -1, 1'b0, bc, dc);
        chk("golden match pass", PI_W'(pass), PI_W'(1));
        run($urandom, 2, 1'b0, 6'h01, 32'h4, -1, 1'b0, bc, dc);
        chk("golden miss pass", PI_W'(pass), '0);
`endif

        // Asynchronous reset mid-run.
        @(posedge clock); #1;
        seed = $urandom; num_pat = CNT_W'(50); po_mode = 1'b1; start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
        repeat (210) @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        chk("async reset busy", PI_W'(busy), '0);
        chk("async reset done", PI_W'(done), '0);
        chk("async reset pi_o", pi_o, '0);
        chk("async reset signature", PI_W'(signature), '0);
        @(negedge clock); #2 reset_n = 1'b1;
        dc = 0;
        repeat (60) begin
            @(negedge clock);
            if (done) dc++;
        end
        chk("after reset done count", PI_W'(dc), '0);

        // Randomized runs.
        for (int i = 0; i < 12; i++) begin
            n  = $urandom_range(0, 15);
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(0, PI_W + n) : -1;
            run($urandom, n, 1'($urandom_range(0, 1)), PO_W'($urandom), $urandom, ab,
                (n >= 10) && ($urandom_range(0, 1) == 1), bc, dc);
        end

        // Full-range pattern count, no wrap-around.
        run($urandom, (1 << CNT_W) - 1, 1'b1, 6'h00, 32'h0, -1, 1'b0, bc, dc);
        chk("max done count", PI_W'(dc), PI_W'(1));
        chk("max busy cycles", PI_W'(bc), PI_W'(PI_W + (1 << CNT_W)));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bench_bist.md
BENCH_BIST -- requirements
Module: bench_bist

Interface
REQ-001 Parameter PI_W, default 192, SHALL set the width of the pattern bus driven into the benchmark's primary inputs.
REQ-002 Parameter PO_W, default 6, range 1..32, SHALL set the width of the benchmark response bus.
REQ-003 Parameter CNT_W, default 16, SHALL set the width of the pattern-count input.
REQ-004 clock  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 start  input  1  SHALL request a run; it is sampled only in IDLE.
REQ-007 abort  input  1  SHALL terminate a run in progress.
REQ-008 num_pat  input  CNT_W  SHALL give the number of compacted patterns; it is sampled with start.
REQ-009 seed  input  32  SHALL give the LFSR seed; it is sampled with start.
REQ-010 pi_o  output  PI_W  SHALL be the pattern register, wired to the benchmark's pi inputs.
REQ-011 po_i  input  PO_W  SHALL be the benchmark's po outputs, combinational from pi_o.
REQ-012 busy  output  1  SHALL be high in LOAD, FILL and RUN.
REQ-013 done  output  1  SHALL be a one-cycle completion pulse.
REQ-014 signature  output  32  SHALL be the MISR contents.

Function
REQ-015 The FSM SHALL have states IDLE, LOAD, FILL, RUN and DONE.
REQ-016 IDLE with start=1 SHALL go to LOAD; num_pat and seed are latched and the MISR is cleared to 0.
REQ-017 LOAD SHALL last 1 cycle and load lfsr with seed, or with 32'h00000001 if seed==0, then go to FILL.
REQ-018 FILL SHALL last exactly PI_W cycles: each cycle pi_o <= {pi_o[PI_W-2:0], lfsr[31]} and the LFSR advances; the MISR does not update.
REQ-019 RUN SHALL last exactly the latched num_pat cycles: the pattern and LFSR shift as in FILL, and the MISR absorbs the po_i value present at that edge.
REQ-020 If the latched num_pat==0, FILL SHALL go directly to DONE.
REQ-021 LFSR and MISR SHALL both use polynomial 0x00400007 in Galois form: next = {r[30:0],1'b0} ^ (r[31] ? 32'h00400007 : 0).
REQ-022 The MISR SHALL additionally XOR po_i, zero-extended to 32 bits, into the result.
REQ-023 DONE SHALL last 1 cycle with done=1 and busy=0, then go to IDLE.
REQ-024 signature SHALL hold its value from DONE until the next accepted start.
REQ-025 start outside IDLE SHALL be ignored.
REQ-026 abort in LOAD, FILL or RUN SHALL go to IDLE on the next edge with no done pulse; signature is cleared to 0.
REQ-027 abort SHALL take priority over every other transition.
REQ-028 abort in IDLE or DONE SHALL have no effect.
REQ-029 start and abort high together in IDLE SHALL be treated as no start.
REQ-030 The RUN counter SHALL count down from num_pat; num_pat = 2^CNT_W-1 SHALL run fully, with no wrap-around.
REQ-031 pi_o SHALL be held constant in IDLE and DONE.

Reset
REQ-032 reset_n low SHALL set, immediately and independent of clock: state=IDLE, pi_o=0, lfsr=0, MISR/signature=0, counters=0, busy=0, done=0.
REQ-033 Reset asserted mid-run SHALL abandon the run with no done pulse.
REQ-034 Outputs SHALL remain at their reset values until the first accepted start after reset_n rises.

Configuration
REQ-035 With BENCH_BIST_GOLDEN_EN defined, the block SHALL add input golden[31:0], sampled with start, and output pass (1 bit).
REQ-036 Under BENCH_BIST_GOLDEN_EN, pass SHALL be set in DONE to (MISR==golden) and held until the next accepted start.
REQ-037 Under BENCH_BIST_GOLDEN_EN, reset and abort SHALL clear pass to 0.
REQ-038 Without BENCH_BIST_GOLDEN_EN, the golden and pass ports and their logic SHALL be absent.
REQ-039 All other behaviour SHALL be identical with and without BENCH_BIST_GOLDEN_EN.

Verification
REQ-040 Reset: pulse reset_n low asynchronously mid-RUN -> busy=0, done=0, pi_o=0 and signature=0 immediately; no done pulse follows.
REQ-041 Zero-length run: start with num_pat=0 and seed=0 -> busy high for 193 cycles (1 LOAD + 192 FILL); done pulses once on the next cycle; signature=0; pi_o[0] after the first FILL shift = 0 (lfsr=1, so lfsr[31]=0).
REQ-042 Constant response: po_i=6'h01, num_pat=1 -> signature=0x00000001; num_pat=2 -> signature=0x00000003; num_pat=3 -> signature=0x00000007.
REQ-043 Quiet response: po_i=0, num_pat=100 -> signature=0x00000000 and done pulses exactly once.
REQ-044 Ignored start and abort: start held high during RUN -> no restart and a single done; abort in RUN cycle 5 of num_pat=50 -> IDLE next cycle, no done, signature=0.
REQ-045 Golden check: with BENCH_BIST_GOLDEN_EN, golden=0x00000003, po_i=6'h01, num_pat=2 -> pass=1; golden=0x00000004 -> pass=0.
